// File: rtl/tpg_timing_ctrl.sv
// Timing controller for tpg. It keeps a shadow copy of the timing fields that
// software writes, and copies it to the active outputs only while tpg is held in reset.
module tpg_timing_ctrl #(
  parameter int H_BITS  = 12,
  parameter int V_BITS  = 12,
  parameter int CFG_W   = 12,
  parameter int RST_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_addr,
  input  logic [CFG_W-1:0]  cfg_wdata,
  input  logic              cfg_commit,
  input  logic              tpg_vs,
  output logic              tpg_rst_n,
  output logic [H_BITS-1:0] tHS_START,
  output logic [H_BITS-1:0] tHS_END,
  output logic [H_BITS-1:0] tHACT_START,
  output logic [H_BITS-1:0] tHACT_END,
  output logic [H_BITS-1:0] tH_END,
  output logic [V_BITS-1:0] tVS_START,
  output logic [V_BITS-1:0] tVS_END,
  output logic [V_BITS-1:0] tVACT_START,
  output logic [V_BITS-1:0] tVACT_END,
  output logic [V_BITS-1:0] tV_END,
  output logic              busy,
  output logic              cfg_err,
  output logic [15:0]       frame_cnt
);

  localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_FRAME, SWAP} state_t;
  state_t state, state_nxt;

  logic [H_BITS-1:0] sh_h  [5];
  logic [V_BITS-1:0] sh_v  [5];
  logic [H_BITS-1:0] act_h [5];
  logic [V_BITS-1:0] act_v [5];
  logic [CW-1:0]     cnt;
  logic              vs_q, cfg_valid, shadow_ok, boundary, swap_entry;
  logic [3:0]        v_addr;

  assign v_addr = cfg_addr - 4'd5;

  // A zero period would stall tpg, and an empty active window is also rejected.
  assign shadow_ok = (sh_h[4] != '0) && (sh_v[4] != '0) &&
                     (sh_h[2] < sh_h[3]) && (sh_h[3] <= sh_h[4]) &&
                     (sh_v[2] < sh_v[3]) && (sh_v[3] <= sh_v[4]);

  assign boundary   = vs_q && !tpg_vs;
  assign swap_entry = (state_nxt == SWAP) && (state != SWAP);
  assign busy       = (state == WAIT_FRAME) || (state == SWAP);
  assign tpg_rst_n  = (state == RUN) || (state == WAIT_FRAME);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (cfg_commit && shadow_ok)  state_nxt = SWAP;
                  else if (enable && cfg_valid) state_nxt = RUN;
      RUN:        if (cfg_commit && shadow_ok)  state_nxt = WAIT_FRAME;
                  else if (!enable)             state_nxt = IDLE;
      WAIT_FRAME: if (boundary || !enable)      state_nxt = SWAP;
      SWAP:       if (cnt == CNT_LAST)          state_nxt = enable ? RUN : IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vs_q      <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
      frame_cnt <= '0;
      cnt       <= '0;
      for (int i = 0; i < 5; i++) begin
        sh_h[i]  <= '0;
        sh_v[i]  <= '0;
        act_h[i] <= '0;
        act_v[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      vs_q  <= tpg_vs;
      cnt   <= (state == SWAP) ? cnt + 1'b1 : '0;
      if (cfg_wr) begin
        if (cfg_addr < 4'd5)       sh_h[cfg_addr[2:0]] <= cfg_wdata[H_BITS-1:0];
        else if (cfg_addr < 4'd10) sh_v[v_addr[2:0]]   <= cfg_wdata[V_BITS-1:0];
      end
      if (cfg_commit && !busy) cfg_err <= !shadow_ok;
      // The swap reset takes priority over a boundary that arrives in the same cycle.
      if (swap_entry) begin
        act_h     <= sh_h;
        act_v     <= sh_v;
        cfg_valid <= 1'b1;
        frame_cnt <= '0;
      end else if (boundary && tpg_rst_n) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign tHS_START   = act_h[0];
  assign tHS_END     = act_h[1];
  assign tHACT_START = act_h[2];
  assign tHACT_END   = act_h[3];
  assign tH_END      = act_h[4];
  assign tVS_START   = act_v[0];
  assign tVS_END     = act_v[1];
  assign tVACT_START = act_v[2];
  assign tVACT_END   = act_v[3];
  assign tV_END      = act_v[4];

endmodule
